// File: rtl/cond_unit_dual_if.sv
// cond_unit_dual_if: per-slot EX-stage controls, flags and gated outputs of the dual condition unit
interface cond_unit_dual_if #(parameter int CNT_WIDTH = 16);
  logic [3:0] i_Cond1E, i_Cond2E, i_ALUFlags1, i_ALUFlags2;
  logic i_FlagWrite1E, i_FlagWrite2E;
  logic i_PCSrc1E, i_RegWrite1E, i_MemWrite1E, i_Branch1E;
  logic i_PCSrc2E, i_RegWrite2E, i_MemWrite2E, i_Branch2E;
  logic i_CntClr;
  logic [3:0] o_Flags;
  logic o_CondEx1, o_CondEx2;
  logic o_PCSrc1, o_RegWrite1, o_MemWrite1;
  logic o_PCSrc2, o_RegWrite2, o_MemWrite2;
  logic o_BranchTaken;
  logic [1:0] o_PCSel;
  logic o_FlushD, o_FlushE;
  logic [CNT_WIDTH-1:0] o_TakenCnt, o_SquashCnt;
  modport master (
    output i_Cond1E, i_Cond2E, i_ALUFlags1, i_ALUFlags2, i_FlagWrite1E, i_FlagWrite2E,
           i_PCSrc1E, i_RegWrite1E, i_MemWrite1E, i_Branch1E,
           i_PCSrc2E, i_RegWrite2E, i_MemWrite2E, i_Branch2E, i_CntClr,
    input  o_Flags, o_CondEx1, o_CondEx2, o_PCSrc1, o_RegWrite1, o_MemWrite1,
           o_PCSrc2, o_RegWrite2, o_MemWrite2, o_BranchTaken, o_PCSel,
           o_FlushD, o_FlushE, o_TakenCnt, o_SquashCnt
  );
  modport slave (
    input  i_Cond1E, i_Cond2E, i_ALUFlags1, i_ALUFlags2, i_FlagWrite1E, i_FlagWrite2E,
           i_PCSrc1E, i_RegWrite1E, i_MemWrite1E, i_Branch1E,
           i_PCSrc2E, i_RegWrite2E, i_MemWrite2E, i_Branch2E, i_CntClr,
    output o_Flags, o_CondEx1, o_CondEx2, o_PCSrc1, o_RegWrite1, o_MemWrite1,
           o_PCSrc2, o_RegWrite2, o_MemWrite2, o_BranchTaken, o_PCSel,
           o_FlushD, o_FlushE, o_TakenCnt, o_SquashCnt
  );
endinterface

// File: rtl/cond_unit_dual.sv
// cond_unit_dual: dual-slot condition gating with NZCV register, slot-2 squash, flush and perf counters
module cond_unit_dual #(
  parameter int CNT_WIDTH = 16,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input logic clk,
  input logic rst_n,
  cond_unit_dual_if.slave bus
);
  function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
    logic p;
    p = 1'b1;
    case (cc[3:1])
      3'd0: p = f[2];
      3'd1: p = f[1];
      3'd2: p = f[3];
      3'd3: p = f[0];
      3'd4: p = f[1] & ~f[2];
      3'd5: p = f[3] == f[0];
      3'd6: p = ~f[2] & (f[3] == f[0]);
      default: p = 1'b1;
    endcase
    return cc[3:1] == 3'd7 ? 1'b1 : p ^ cc[0];
  endfunction
  logic [3:0] flags_q, flags_d, f1;
  logic [CNT_WIDTH-1:0] taken_cnt_q, taken_cnt_d, squash_cnt_q, squash_cnt_d;
  logic cond_ex1, cond_ex2, taken1, taken2, squash2;
  always_comb begin
    cond_ex1 = cond_pass(bus.i_Cond1E, flags_q);
    taken1 = cond_ex1 & (bus.i_PCSrc1E | bus.i_Branch1E);
    squash2 = taken1;
    f1 = cond_ex1 & bus.i_FlagWrite1E ? bus.i_ALUFlags1 : flags_q;
    cond_ex2 = cond_pass(bus.i_Cond2E, f1) & ~squash2;
    taken2 = cond_ex2 & (bus.i_PCSrc2E | bus.i_Branch2E);
    flags_d = cond_ex2 & bus.i_FlagWrite2E ? bus.i_ALUFlags2 : f1;
    taken_cnt_d = bus.i_CntClr ? '0 : taken_cnt_q + CNT_WIDTH'(taken1 | taken2);
    squash_cnt_d = bus.i_CntClr ? '0 : squash_cnt_q + CNT_WIDTH'(squash2);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= FLAGS_RST;
      taken_cnt_q <= '0;
      squash_cnt_q <= '0;
    end else begin
      flags_q <= flags_d;
      taken_cnt_q <= taken_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end
  assign bus.o_Flags = flags_q;
  assign bus.o_CondEx1 = cond_ex1;
  assign bus.o_CondEx2 = cond_ex2;
  assign bus.o_PCSrc1 = bus.i_PCSrc1E & cond_ex1;
  assign bus.o_RegWrite1 = bus.i_RegWrite1E & cond_ex1;
  assign bus.o_MemWrite1 = bus.i_MemWrite1E & cond_ex1;
  assign bus.o_PCSrc2 = bus.i_PCSrc2E & cond_ex2;
  assign bus.o_RegWrite2 = bus.i_RegWrite2E & cond_ex2;
  assign bus.o_MemWrite2 = bus.i_MemWrite2E & cond_ex2;
  assign bus.o_BranchTaken = taken1 | taken2;
  assign bus.o_PCSel = taken1 ? 2'b01 : taken2 ? 2'b10 : 2'b00;
  assign bus.o_FlushD = taken1 | taken2;
  assign bus.o_FlushE = taken1 | taken2;
  assign bus.o_TakenCnt = taken_cnt_q;
  assign bus.o_SquashCnt = squash_cnt_q;
endmodule

// File: doc/cond_unit_dual.md
# cond_unit_dual

Dual-slot execute-stage condition unit for the two-wide pipeline. It consumes the per-slot control, condition and ALU-flag signals leaving the ID/EX register, holds the architectural NZCV flags, and gates each slot's write-back, memory and PC side effects by its condition code. It also squashes slot 2 when slot 1 redirects the PC, drives the D/E flush back to the front-end and ID/EX register, and keeps taken-branch and squash counters.

## Interface
- CNT_WIDTH, 16, width of performance counters
- FLAGS_RST, 4'b0000, NZCV reset value
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_Cond1E, i_Cond2E  in  4 each  condition field per slot
- i_ALUFlags1, i_ALUFlags2  in  4 each  NZCV from slot ALUs, bit3=N, 2=Z, 1=C, 0=V
- i_FlagWrite1E, i_FlagWrite2E  in  1 each  slot updates NZCV
- i_PCSrc1E, i_RegWrite1E, i_MemWrite1E, i_Branch1E  in  1 each  slot-1 raw controls
- i_PCSrc2E, i_RegWrite2E, i_MemWrite2E, i_Branch2E  in  1 each  slot-2 raw controls
- i_CntClr  in  1  synchronous counter clear
- o_Flags  out  4  architectural NZCV register
- o_CondEx1, o_CondEx2  out  1 each  slot condition passed; o_CondEx2 is 0 when squashed
- o_PCSrc1, o_RegWrite1, o_MemWrite1  out  1 each  gated slot-1 controls
- o_PCSrc2, o_RegWrite2, o_MemWrite2  out  1 each  gated slot-2 controls
- o_BranchTaken  out  1  a slot redirects the PC this cycle
- o_PCSel  out  2  01 = slot-1 target, 10 = slot-2 target, 00 = none
- o_FlushD, o_FlushE  out  1 each  flush IF/ID and ID/EX, both slots
- o_TakenCnt, o_SquashCnt  out  CNT_WIDTH each  performance counters

## Operation
- Condition decode (cc, flags N,Z,C,V):
  - 0000 EQ Z; 0001 NE !Z
  - 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N
  - 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 1
- Slot 1 evaluates against o_Flags.
- Slot 2 evaluates against F1. F1 = i_ALUFlags1 when CondEx1 & i_FlagWrite1E, else o_Flags. This is the intra-bundle bypass.
- Taken1 = CondEx1 & (i_PCSrc1E | i_Branch1E). Squash2 = Taken1.
- CondEx2 = cond2(F1) & !Squash2. Taken2 = CondEx2 & (i_PCSrc2E | i_Branch2E).
- Gated controls: o_XxxN = i_XxxNE & CondExN, for PCSrc, RegWrite and MemWrite.
- o_BranchTaken = Taken1 | Taken2. o_PCSel = Taken1 ? 01 : Taken2 ? 10 : 00.
- o_FlushD = o_FlushE = o_BranchTaken.
- Next flags:
  - F2 = i_ALUFlags2 if CondEx2 & i_FlagWrite2E, else F1.
  - o_Flags <= F2 each clock edge. Slot 2 wins when both slots write.
- Counters, updated on each clock edge:
  - i_CntClr has priority: both counters <= 0.
  - Otherwise TakenCnt += o_BranchTaken; SquashCnt += Squash2.
  - Both counters wrap modulo 2^CNT_WIDTH.
- A flushed bubble (all controls 0) has no effect regardless of cond.

## Timing
- All gating, PCSel and flush outputs are combinational from current inputs and o_Flags, with zero-cycle latency.
- o_Flags and the counters are registered. They are visible the cycle after the updating instruction.
- Reset (async, any time, including mid-branch):
  - o_Flags = FLAGS_RST; o_TakenCnt = o_SquashCnt = 0.
  - Combinational outputs follow inputs evaluated against FLAGS_RST.
- Reset release: first clock edge with rst_n=1 performs a normal update.
- Simultaneous Taken1 and slot-2 branch: slot 2 is squashed; PCSel=01; SquashCnt +1, TakenCnt +1.
- Squashed slot 2 never writes flags, registers, memory or PC.

## Test plan
- Reset then idle:
  - o_Flags=0000, counters 0.
  - Cond1=0000 (EQ) with RegWrite1 -> o_RegWrite1=0.
  - Cond1=1110 (AL) -> o_RegWrite1=1.
- Intra-bundle bypass:
  - Stimulus: o_Flags=0000; slot 1 AL, FlagWrite, ALUFlags1=0100; slot 2 EQ, RegWrite.
  - Response: o_RegWrite2=1; next cycle o_Flags=0100.
- Both write flags:
  - Stimulus: ALUFlags1=1000, ALUFlags2=0001, both AL, both FlagWrite.
  - Response: next o_Flags=0001.
- Slot-1 branch squash:
  - Stimulus: slot 1 AL Branch; slot 2 AL MemWrite, FlagWrite.
  - Response: o_PCSel=01, o_FlushD=o_FlushE=1, o_MemWrite2=0, flags unchanged, TakenCnt=1, SquashCnt=1.
- Slot-2 branch, slot-1 not taken:
  - Stimulus: slot 1 NE with Z=1, Branch; slot 2 AL PCSrc.
  - Response: o_PCSel=10, o_PCSrc2=1, SquashCnt unchanged.
- Counter wrap and clear:
  - Force TakenCnt to 0xFFFF, take a branch -> 0x0000.
  - Assert i_CntClr together with a taken branch -> counters 0.
  - Assert rst_n low mid-sequence -> o_Flags=FLAGS_RST immediately.
